// File: rtl/beta_pipe_ctrl_n_if.sv
// Control bundle between the issue/retire front end and beta_pipe_ctrl_n.
// Signals are named without direction suffixes; the modports give direction.
interface beta_pipe_ctrl_n_if #(
    parameter int StageNum     = 3,
    parameter int RegAddrWidth = 5
);
    localparam int CW = $clog2(StageNum + 1);

    logic [StageNum-1:0]     pcu_busy;
    logic                    pcu_issue;
    logic                    pcu_issue_rd_we;
    logic [RegAddrWidth-1:0] pcu_issue_rd_addr;
    logic [RegAddrWidth-1:0] pcu_rs1_addr;
    logic [RegAddrWidth-1:0] pcu_rs2_addr;
    logic                    pcu_rs1_used;
    logic                    pcu_rs2_used;
    logic                    pcu_retire;
    logic                    pcu_retire_rd_we;
    logic [RegAddrWidth-1:0] pcu_retire_rd_addr;
    logic                    pcu_redirect;
    logic                    pcu_fetch_en;
    logic [StageNum-2:0]     pcu_stall;
    logic [StageNum-2:0]     pcu_flush;
    logic                    pcu_hazard;
    logic [CW-1:0]           pcu_inflight;
    logic                    pcu_sb_err;

    modport master (
        output pcu_busy, pcu_issue, pcu_issue_rd_we, pcu_issue_rd_addr,
               pcu_rs1_addr, pcu_rs2_addr, pcu_rs1_used, pcu_rs2_used,
               pcu_retire, pcu_retire_rd_we, pcu_retire_rd_addr, pcu_redirect,
        input  pcu_fetch_en, pcu_stall, pcu_flush, pcu_hazard, pcu_inflight, pcu_sb_err
    );

    modport slave (
        input  pcu_busy, pcu_issue, pcu_issue_rd_we, pcu_issue_rd_addr,
               pcu_rs1_addr, pcu_rs2_addr, pcu_rs1_used, pcu_rs2_used,
               pcu_retire, pcu_retire_rd_we, pcu_retire_rd_addr, pcu_redirect,
        output pcu_fetch_en, pcu_stall, pcu_flush, pcu_hazard, pcu_inflight, pcu_sb_err
    );
endinterface

// File: rtl/beta_pipe_ctrl_n.sv
// In-order pipeline controller: fetch gating, per-stage stall/flush, RAW
// scoreboard with in-flight count and sticky bookkeeping error.
//
// state    | meaning
// ST_IDLE  | one settle cycle after reset; outputs held quiet, bookkeeping off
// ST_RUN   | normal issue/retire operation, fetch may be enabled
// ST_FLUSH | fetch blocked after a redirect until the flush down-counter hits 0
module beta_pipe_ctrl_n #(
    parameter int StageNum     = 3,
    parameter int FlushCycles  = 1,
    parameter int RegAddrWidth = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    beta_pipe_ctrl_n_if.slave bus
);
    localparam int CW   = $clog2(StageNum + 1);
    localparam int NReg = 2 ** RegAddrWidth;
    localparam int FW   = 3;
    localparam logic [CW-1:0] InflMax   = CW'(StageNum);
    localparam logic [FW-1:0] FlushLoad = FW'(FlushCycles);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [FW-1:0]       flush_cnt_q, flush_cnt_d;
    logic [CW-1:0]       pend_q [NReg];
    logic [CW-1:0]       pend_d [NReg];
    logic [CW-1:0]       infl_q, infl_d;
    logic                err_q, err_d;
    logic                active, live, hazard_raw;
    logic                sb_inc, sb_dec, sb_same;
    logic [StageNum-2:0] stall_raw, bubble_vec, flush_v;

    assign active     = (state_q != ST_IDLE);
    assign live       = active & ~rst_i;
    // Entry 0 is never written, so r0 always reads as not pending.
    assign hazard_raw = (bus.pcu_rs1_used & (pend_q[bus.pcu_rs1_addr] != '0))
                      | (bus.pcu_rs2_used & (pend_q[bus.pcu_rs2_addr] != '0));
    assign sb_inc  = bus.pcu_issue & bus.pcu_issue_rd_we & (bus.pcu_issue_rd_addr != '0);
    assign sb_dec  = bus.pcu_retire & bus.pcu_retire_rd_we & (bus.pcu_retire_rd_addr != '0);
    assign sb_same = sb_inc & sb_dec & (bus.pcu_issue_rd_addr == bus.pcu_retire_rd_addr);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            ST_IDLE: state_d = ST_RUN;
            ST_RUN: begin
                if (bus.pcu_redirect) begin
                    state_d     = ST_FLUSH;
                    flush_cnt_d = FlushLoad;
                end
            end
            ST_FLUSH: begin
                if (bus.pcu_redirect) begin
                    flush_cnt_d = FlushLoad;
                end else if (flush_cnt_q == FW'(1)) begin
                    state_d     = ST_RUN;
                    flush_cnt_d = '0;
                end else begin
                    flush_cnt_d = flush_cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int r = 0; r < NReg; r++) pend_q[r] <= '0;
            infl_q <= '0;
            err_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            infl_q <= infl_d;
            err_q  <= err_d;
        end
    end

    // A redirect wipes the in-flight window, so same-cycle issue/retire are dropped.
    always_comb begin
        pend_d = pend_q;
        infl_d = infl_q;
        err_d  = err_q;
        if (active) begin
            if (bus.pcu_redirect) begin
                for (int r = 0; r < NReg; r++) pend_d[r] = '0;
                infl_d = '0;
            end else begin
                if (bus.pcu_issue & hazard_raw) err_d = 1'b1;
                if (bus.pcu_issue & ~bus.pcu_retire) begin
                    if (infl_q == InflMax) err_d = 1'b1;
                    else                   infl_d = infl_q + 1'b1;
                end else if (bus.pcu_retire & ~bus.pcu_issue) begin
                    if (infl_q == '0) err_d = 1'b1;
                    else              infl_d = infl_q - 1'b1;
                end
                if (!sb_same) begin
                    if (sb_inc && pend_q[bus.pcu_issue_rd_addr] != '1)
                        pend_d[bus.pcu_issue_rd_addr] = pend_q[bus.pcu_issue_rd_addr] + 1'b1;
                    if (sb_dec) begin
                        if (pend_q[bus.pcu_retire_rd_addr] == '0)
                            err_d = 1'b1;
                        else
                            pend_d[bus.pcu_retire_rd_addr] = pend_q[bus.pcu_retire_rd_addr] - 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        stall_raw = '0;
        for (int j = 0; j < StageNum - 1; j++) stall_raw[j] = |(bus.pcu_busy >> (j + 1));
        stall_raw[0] = stall_raw[0] | hazard_raw;
    end

    // On a decode hazard with stage 1 free, clear pipe register 1 to insert a bubble.
    if (StageNum >= 3) begin : g_bubble
        assign bubble_vec = (StageNum-1)'({hazard_raw & ~stall_raw[1], 1'b0});
    end else begin : g_no_bubble
        assign bubble_vec = '0;
    end

    always_comb begin
        flush_v          = '1;
        bus.pcu_fetch_en = 1'b0;
        bus.pcu_stall    = '0;
        bus.pcu_flush    = '1;
        bus.pcu_hazard   = 1'b0;
        bus.pcu_inflight = '0;
        bus.pcu_sb_err   = 1'b0;
        if (live) begin
            flush_v          = {(StageNum-1){bus.pcu_redirect}} | bubble_vec;
            bus.pcu_flush    = flush_v;
            bus.pcu_stall    = stall_raw & ~flush_v;
            bus.pcu_hazard   = hazard_raw;
            bus.pcu_fetch_en = (state_q == ST_RUN) & ~bus.pcu_redirect & ~hazard_raw
                             & ~(|bus.pcu_busy);
            bus.pcu_inflight = infl_q;
            bus.pcu_sb_err   = err_q;
        end
    end
endmodule
